// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// alu_ctrl_pkg : ALU control codes, decode field values and MDU FSM encoding
// Rev 1.0
// ============================================================================
package alu_ctrl_pkg;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_NOT = 4'b0010;
   localparam logic [3:0] ALU_SL  = 4'b0011;
   localparam logic [3:0] ALU_SR  = 4'b0100;
   localparam logic [3:0] ALU_AND = 4'b0101;
   localparam logic [3:0] ALU_OR  = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_MUL = 4'b1000;
   localparam logic [3:0] ALU_DIV = 4'b1001;

   localparam logic [2:0] ALUOP_RTYPE  = 3'b000;
   localparam logic [2:0] ALUOP_BRANCH = 3'b001;
   localparam logic [2:0] ALUOP_SLTI   = 3'b010;
   localparam logic [2:0] ALUOP_MDU    = 3'b011;

   localparam logic [5:0] FUNCT_ADD = 6'b000000;
   localparam logic [5:0] FUNCT_SUB = 6'b000001;
   localparam logic [5:0] FUNCT_AND = 6'b000010;
   localparam logic [5:0] FUNCT_OR  = 6'b000011;
   localparam logic [5:0] FUNCT_SLT = 6'b000100;
   localparam logic [5:0] FUNCT_SL  = 6'b000101;
   localparam logic [5:0] FUNCT_SR  = 6'b000110;
   localparam logic [5:0] FUNCT_NOT = 6'b000111;

   localparam logic [2:0] MDU_NONE = 3'b000;
   localparam logic [2:0] MDU_MUL  = 3'b001;
   localparam logic [2:0] MDU_DIV  = 3'b010;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_MUL_RUN = 2'b01,
      ST_DIV_RUN = 2'b10,
      ST_DONE    = 2'b11
   } mdu_state_e;

   function automatic logic is_mdu_code(input logic [3:0] code);
      return (code == ALU_MUL) || (code == ALU_DIV);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
// mdu_iter : iterative shift-add multiplier / restoring divider, one step/cycle
// Optional macro ALU_CTRL_MDU_SIGNED_EN selects two's-complement operation.
// Rev 1.0
// ============================================================================
module mdu_iter #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              op_div_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic              done_o,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o
);
   localparam int               CNT_W     = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

   logic [DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0] qr_q, qr_d;
   logic [DATA_W-1:0] opd_q, opd_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              run_q, run_d;
   logic              div_q, div_d;

   logic [DATA_W-1:0] a_mag, b_mag;
   logic [DATA_W-1:0] addend;
   logic [DATA_W:0]   sum;
   logic [DATA_W:0]   shifted;
   logic              ge;
   logic [DATA_W-1:0] acc_step, qr_step;

`ifdef ALU_CTRL_MDU_SIGNED_EN
   logic neg_a_q, neg_b_q;

   assign a_mag = a_i[DATA_W-1] ? -a_i : a_i;
   assign b_mag = b_i[DATA_W-1] ? -b_i : b_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         neg_a_q <= 1'b0;
         neg_b_q <= 1'b0;
      end else if (start_i) begin
         neg_a_q <= a_i[DATA_W-1];
         neg_b_q <= b_i[DATA_W-1];
      end
   end

   // Quotient/product sign is the XOR of operand signs; remainder follows dividend.
   always_comb begin
      hi_o = acc_step;
      lo_o = qr_step;
      if (div_q) begin
         if (neg_a_q ^ neg_b_q) lo_o = -qr_step;
         if (neg_a_q)           hi_o = -acc_step;
      end else if (neg_a_q ^ neg_b_q) begin
         {hi_o, lo_o} = -{acc_step, qr_step};
      end
   end
`else
   assign a_mag = a_i;
   assign b_mag = b_i;
   assign hi_o  = acc_step;
   assign lo_o  = qr_step;
`endif

   // Multiply: {acc,qr} shifts right, qr starts as the multiplier.
   // Divide:   {acc,qr} shifts left, qr collects quotient bits.
   always_comb begin
      addend  = qr_q[0] ? opd_q : '0;
      sum     = {1'b0, acc_q} + {1'b0, addend};
      shifted = {acc_q, qr_q[DATA_W-1]};
      ge      = shifted >= {1'b0, opd_q};
      if (div_q) begin
         acc_step = ge ? (shifted[DATA_W-1:0] - opd_q) : shifted[DATA_W-1:0];
         qr_step  = {qr_q[DATA_W-2:0], ge};
      end else begin
         acc_step = sum[DATA_W:1];
         qr_step  = {sum[0], qr_q[DATA_W-1:1]};
      end
   end

   assign done_o = run_q && (cnt_q == LAST_STEP);

   always_comb begin
      run_d = run_q;
      div_d = div_q;
      cnt_d = cnt_q;
      acc_d = acc_q;
      qr_d  = qr_q;
      opd_d = opd_q;
      if (start_i) begin
         run_d = 1'b1;
         div_d = op_div_i;
         cnt_d = '0;
         acc_d = '0;
         qr_d  = op_div_i ? a_mag : b_mag;
         opd_d = op_div_i ? b_mag : a_mag;
      end else if (run_q) begin
         acc_d = acc_step;
         qr_d  = qr_step;
         cnt_d = cnt_q + CNT_W'(1);
         if (done_o) run_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         run_q <= 1'b0;
         div_q <= 1'b0;
         cnt_q <= '0;
         acc_q <= '0;
         qr_q  <= '0;
         opd_q <= '0;
      end else begin
         run_q <= run_d;
         div_q <= div_d;
         cnt_q <= cnt_d;
         acc_q <= acc_d;
         qr_q  <= qr_d;
         opd_q <= opd_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/alu_ctrl_mdu.sv
`default_nettype none
// ============================================================================
// alu_ctrl_mdu : ALU control decoder with multi-cycle MUL/DIV sequencing
// Optional macro ALU_CTRL_MDU_SIGNED_EN makes MUL/DIV two's-complement.
// Rev 1.0
// ============================================================================
module alu_ctrl_mdu
   import alu_ctrl_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [2:0]        alu_op_i,
   input  logic [2:0]        type_i,
   input  logic [5:0]        funct_i,
   input  logic [DATA_W-1:0] op_a_i,
   input  logic [DATA_W-1:0] op_b_i,
   output logic [3:0]        alu_cnt_o,
   output logic              dec_err_o,
   output logic              stall_o,
   output logic              mdu_valid_o,
   output logic [DATA_W-1:0] mdu_hi_o,
   output logic [DATA_W-1:0] mdu_lo_o
);
   logic [3:0]        alu_cnt;
   logic              dec_err;
   mdu_state_e        state_q, state_d;
   logic [DATA_W-1:0] mdu_hi_q, mdu_hi_d;
   logic [DATA_W-1:0] mdu_lo_q, mdu_lo_d;
   logic              mdu_req;
   logic              iter_start;
   logic              iter_div;
   logic              iter_done;
   logic [DATA_W-1:0] iter_hi, iter_lo;
   logic              running;

   always_comb begin : decode
      alu_cnt = ALU_ADD;
      dec_err = 1'b0;
      case (alu_op_i)
         ALUOP_RTYPE: begin
            case (funct_i)
               FUNCT_ADD: alu_cnt = ALU_ADD;
               FUNCT_SUB: alu_cnt = ALU_SUB;
               FUNCT_AND: alu_cnt = ALU_AND;
               FUNCT_OR:  alu_cnt = ALU_OR;
               FUNCT_SLT: alu_cnt = ALU_SLT;
               FUNCT_SL:  alu_cnt = ALU_SL;
               FUNCT_SR:  alu_cnt = ALU_SR;
               FUNCT_NOT: alu_cnt = ALU_NOT;
               default:   dec_err = 1'b1;
            endcase
         end
         ALUOP_BRANCH: alu_cnt = ALU_SUB;
         ALUOP_SLTI:   alu_cnt = ALU_SLT;
         ALUOP_MDU: begin
            case (type_i)
               MDU_NONE: alu_cnt = ALU_ADD;
               MDU_MUL:  alu_cnt = ALU_MUL;
               MDU_DIV:  alu_cnt = ALU_DIV;
               default:  dec_err = 1'b1;
            endcase
         end
         default: dec_err = 1'b1;
      endcase
   end

   assign mdu_req  = in_valid_i && is_mdu_code(alu_cnt);
   assign iter_div = (alu_cnt == ALU_DIV);

   always_comb begin : fsm_next
      state_d    = state_q;
      mdu_hi_d   = mdu_hi_q;
      mdu_lo_d   = mdu_lo_q;
      iter_start = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (mdu_req) begin
               // Divide by zero never enters the iterative engine.
               if (iter_div && (op_b_i == '0)) begin
                  state_d  = ST_DONE;
                  mdu_hi_d = op_a_i;
                  mdu_lo_d = '1;
               end else begin
                  iter_start = 1'b1;
                  state_d    = iter_div ? ST_DIV_RUN : ST_MUL_RUN;
               end
            end
         end
         ST_MUL_RUN, ST_DIV_RUN: begin
            if (iter_done) begin
               state_d  = ST_DONE;
               mdu_hi_d = iter_hi;
               mdu_lo_d = iter_lo;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         mdu_hi_q <= '0;
         mdu_lo_q <= '0;
      end else begin
         state_q  <= state_d;
         mdu_hi_q <= mdu_hi_d;
         mdu_lo_q <= mdu_lo_d;
      end
   end

   mdu_iter #(
      .DATA_W (DATA_W)
   ) u_mdu_iter (
      .clk      (clk),
      .rst      (rst),
      .start_i  (iter_start),
      .op_div_i (iter_div),
      .a_i      (op_a_i),
      .b_i      (op_b_i),
      .done_o   (iter_done),
      .hi_o     (iter_hi),
      .lo_o     (iter_lo)
   );

   assign running     = (state_q == ST_MUL_RUN) || (state_q == ST_DIV_RUN);
   assign in_ready_o  = !running;
   assign stall_o     = running;
   assign mdu_valid_o = (state_q == ST_DONE);
   assign alu_cnt_o   = alu_cnt;
   assign dec_err_o   = dec_err;
   assign mdu_hi_o    = mdu_hi_q;
   assign mdu_lo_o    = mdu_lo_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_mdu.sv
`default_nettype none
// ============================================================================
// tb_alu_ctrl_mdu : self-checking bench for alu_ctrl_mdu at DATA_W=8
// Honours ALU_CTRL_MDU_SIGNED_EN for the arithmetic reference model.
// Rev 1.0
// ============================================================================
module tb_alu_ctrl_mdu;
   localparam int DW = 8;
   localparam logic [3:0] RCODE [8] = '{4'h0, 4'h1, 4'h5, 4'h6, 4'h7, 4'h3, 4'h4, 4'h2};

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [2:0]    alu_op;
   logic [2:0]    type_s;
   logic [5:0]    funct;
   logic [DW-1:0] op_a, op_b;
   logic [3:0]    alu_cnt;
   logic          dec_err;
   logic          stall;
   logic          mdu_valid;
   logic [DW-1:0] mdu_hi, mdu_lo;

   int            n_cmp  = 0;
   int            n_fail = 0;
   logic [DW-1:0] exp_hi = '0;
   logic [DW-1:0] exp_lo = '0;

   always #5 clk = ~clk;

   alu_ctrl_mdu #(.DATA_W(DW)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .alu_op_i    (alu_op),
      .type_i      (type_s),
      .funct_i     (funct),
      .op_a_i      (op_a),
      .op_b_i      (op_b),
      .alu_cnt_o   (alu_cnt),
      .dec_err_o   (dec_err),
      .stall_o     (stall),
      .mdu_valid_o (mdu_valid),
      .mdu_hi_o    (mdu_hi),
      .mdu_lo_o    (mdu_lo)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [4:0] ref_decode(input logic [2:0] op, input logic [2:0] ty,
                                             input logic [5:0] fn);
      if (op == 3'd0) return (fn < 6'd8) ? {1'b0, RCODE[fn[2:0]]} : 5'b1_0000;
      if (op == 3'd1) return 5'b0_0001;
      if (op == 3'd2) return 5'b0_0111;
      if (op == 3'd3) begin
         if (ty == 3'd0) return 5'b0_0000;
         if (ty == 3'd1) return 5'b0_1000;
         if (ty == 3'd2) return 5'b0_1001;
      end
      return 5'b1_0000;
   endfunction

   function automatic void model(input bit div, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 output logic [DW-1:0] hi, output logic [DW-1:0] lo);
      longint x, y, p, q, r;
`ifdef ALU_CTRL_MDU_SIGNED_EN
      x = longint'($signed(a));
      y = longint'($signed(b));
`else
      x = longint'(a);
      y = longint'(b);
`endif
      if (div) begin
         if (b == '0) begin
            hi = a;
            lo = '1;
         end else begin
            q  = x / y;
            r  = x % y;
            lo = q[DW-1:0];
            hi = r[DW-1:0];
         end
      end else begin
         p        = x * y;
         {hi, lo} = p[2*DW-1:0];
      end
   endfunction

   task automatic drive_non_mdu();
      in_valid = 1'b1;
      alu_op   = 3'($urandom);
      type_s   = 3'($urandom);
      funct    = 6'($urandom);
      op_a     = DW'($urandom);
      op_b     = DW'($urandom);
      if (alu_op == 3'd3 && (type_s == 3'd1 || type_s == 3'd2)) type_s = 3'd0;
   endtask

   task automatic idle_cycles(input int n, input bit busy_in);
      for (int i = 0; i < n; i++) begin
         if (busy_in) drive_non_mdu();
         else in_valid = 1'b0;
         tick();
         check("idle/valid", mdu_valid, 0);
         check("idle/stall", stall, 0);
         check("idle/hi", mdu_hi, exp_hi);
         check("idle/lo", mdu_lo, exp_lo);
      end
      in_valid = 1'b0;
   endtask

   // Issues one MUL/DIV from IDLE or DONE and follows it to its mdu_valid pulse.
   task automatic run_op(input string tag, input bit div, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [DW-1:0] want_hi,
                         input logic [DW-1:0] want_lo);
      int lat;
      int stalls;
      int want_lat;
      want_lat = (div && b == '0) ? 1 : DW + 1;
      in_valid = 1'b1;
      alu_op   = 3'd3;
      type_s   = div ? 3'd2 : 3'd1;
      funct    = 6'($urandom);
      op_a     = a;
      op_b     = b;
      #1;
      check($sformatf("%s/ready", tag), in_ready, 1);
      check($sformatf("%s/code", tag), alu_cnt, div ? 4'b1001 : 4'b1000);
      tick();
      lat    = 1;
      stalls = 0;
      while (mdu_valid !== 1'b1 && lat <= 3 * DW) begin
         if (stall === 1'b1) stalls++;
         check($sformatf("%s/hold_hi", tag), mdu_hi, exp_hi);
         check($sformatf("%s/hold_lo", tag), mdu_lo, exp_lo);
         in_valid = 1'($urandom);
         alu_op   = 3'($urandom);
         type_s   = 3'($urandom);
         funct    = 6'($urandom);
         op_a     = DW'($urandom);
         op_b     = DW'($urandom);
         tick();
         lat++;
      end
      in_valid = 1'b0;
      check($sformatf("%s/latency", tag), lat, want_lat);
      check($sformatf("%s/stall_cycles", tag), stalls, want_lat - 1);
      check($sformatf("%s/hi", tag), mdu_hi, want_hi);
      check($sformatf("%s/lo", tag), mdu_lo, want_lo);
      check($sformatf("%s/done_stall", tag), stall, 0);
      exp_hi = want_hi;
      exp_lo = want_lo;
   endtask

   logic [4:0]    dref;
   logic [DW-1:0] rh, rl, ra, rb;
   bit            rdiv;
   int            nf;

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      alu_op   = '0;
      type_s   = '0;
      funct    = '0;
      op_a     = '0;
      op_b     = '0;
      repeat (3) tick();
      check("reset/ready", in_ready, 1);
      check("reset/stall", stall, 0);
      check("reset/valid", mdu_valid, 0);
      check("reset/hi", mdu_hi, 0);
      check("reset/lo", mdu_lo, 0);
      rst = 1'b0;
      tick();

      for (int op = 0; op < 8; op++) begin
         for (int ty = 0; ty < 8; ty++) begin
            nf = (op == 0) ? 64 : 2;
            for (int f = 0; f < nf; f++) begin
               alu_op = 3'(op);
               type_s = 3'(ty);
               funct  = (op == 0) ? 6'(f) : 6'($urandom);
               #1;
               dref = ref_decode(alu_op, type_s, funct);
               check($sformatf("dec/op%0d/ty%0d/fn%0d/cnt", op, ty, funct), alu_cnt, dref[3:0]);
               check($sformatf("dec/op%0d/ty%0d/fn%0d/err", op, ty, funct), dec_err, dref[4]);
            end
         end
      end
      check("dec/idle_stall", stall, 0);

      idle_cycles(4, 1'b1);

      run_op("mul13x11", 1'b0, 8'd13, 8'd11, 8'h00, 8'h8F);
      idle_cycles(1, 1'b0);
`ifndef ALU_CTRL_MDU_SIGNED_EN
      run_op("mul255x255", 1'b0, 8'd255, 8'd255, 8'hFE, 8'h01);
      idle_cycles(2, 1'b1);
`endif
      run_op("div100by7", 1'b1, 8'd100, 8'd7, 8'd2, 8'd14);
      idle_cycles(1, 1'b0);
      run_op("div55by0", 1'b1, 8'h55, 8'h00, 8'h55, 8'hFF);
      idle_cycles(1, 1'b0);

      // Back-to-back: DIV issued in the MUL's DONE cycle.
      run_op("b2b_mul", 1'b0, 8'd9, 8'd7, 8'h00, 8'd63);
      run_op("b2b_div", 1'b1, 8'd50, 8'd6, 8'd2, 8'd8);
      idle_cycles(1, 1'b0);

`ifdef ALU_CTRL_MDU_SIGNED_EN
      run_op("smul_m6x3", 1'b0, 8'hFA, 8'h03, 8'hFF, 8'hEE);
      idle_cycles(1, 1'b0);
      run_op("sdiv_m7by2", 1'b1, 8'hF9, 8'h02, 8'hFF, 8'hFD);
      idle_cycles(1, 1'b0);
      run_op("sdiv_minbym1", 1'b1, 8'h80, 8'hFF, 8'h00, 8'h80);
      idle_cycles(1, 1'b0);
`endif

      // Reset three cycles into a MUL aborts it with no completion pulse.
      in_valid = 1'b1;
      alu_op   = 3'd3;
      type_s   = 3'd1;
      op_a     = 8'd200;
      op_b     = 8'd3;
      tick();
      in_valid = 1'b0;
      check("abort/running", stall, 1);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst    = 1'b0;
      exp_hi = '0;
      exp_lo = '0;
      check("abort/stall", stall, 0);
      check("abort/ready", in_ready, 1);
      check("abort/valid", mdu_valid, 0);
      check("abort/hi", mdu_hi, 0);
      check("abort/lo", mdu_lo, 0);
      idle_cycles(DW + 3, 1'b0);

      for (int i = 0; i < 24; i++) begin
         rdiv = 1'($urandom);
         ra   = DW'($urandom);
         rb   = DW'($urandom);
         if ($urandom_range(0, 7) == 0) rb = '0;
         model(rdiv, ra, rb, rh, rl);
         run_op($sformatf("rnd%0d_%s_%0h_%0h", i, rdiv ? "div" : "mul", ra, rb),
                rdiv, ra, rb, rh, rl);
         if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3), 1'b1);
      end
      idle_cycles(2, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_ctrl_mdu.md
Name: alu_ctrl_mdu

Overview:
Parametrised successor to the ALU control decoder. It decodes alu_op/type/funct into the 4-bit ALU control code and sequences multi-cycle MUL/DIV through an iterative multiply/divide engine. Busy cycles are reported with a ready/stall handshake. It sits in the EX stage beside the ALU; the hazard unit uses stall to freeze IF/ID/EX.

Parameters:
DATA_W, 32, operand width; legal range 4..64
CNT_W, $clog2(DATA_W+1), iteration counter width; derived localparam, not overridable

Ports:
clk  in  1  clock
rst  in  1  reset
in_valid  in  1  an instruction is present in EX
in_ready  out  1  block can accept an instruction this cycle
alu_op  in  3  main-control ALU op class
type  in  3  sub-op for alu_op=011 (001 MUL, 010 DIV)
funct  in  6  R-type function field
op_a  in  DATA_W  rs operand (multiplicand / dividend)
op_b  in  DATA_W  rt operand (multiplier / divisor)
alu_cnt  out  4  ALU control code
dec_err  out  1  unrecognised encoding
stall  out  1  MDU busy; freeze pipeline
mdu_valid  out  1  one-cycle pulse: mdu_hi/mdu_lo just updated
mdu_hi  out  DATA_W  MUL high word / DIV remainder
mdu_lo  out  DATA_W  MUL low word / DIV quotient

Behaviour:
- Reset is synchronous and active-high on rst, sampled at the clk rising edge.
- Decode is combinational from alu_op/type/funct:
  - R-type funct 000000..000111 → ADD 0000, SUB 0001, AND 0101, OR 0110, SLT 0111, SL 0011, SR 0100, NOT 0010.
  - alu_op 001 → 0001. alu_op 010 → 0111. alu_op 011/type 001 → 1000. alu_op 011/type 010 → 1001. alu_op 011/type 000 → 0000.
  - Every other encoding → alu_cnt=0000, dec_err=1. No X is ever driven.
- Reset values: in_ready=1, stall=0, mdu_valid=0, mdu_hi=0, mdu_lo=0, FSM=IDLE.
- FSM states: IDLE, MUL_RUN, DIV_RUN, DONE.
  - IDLE/DONE: in_ready=1, stall=0.
    - Accept when in_valid & alu_cnt∈{1000,1001}: latch operands, counter=0, go to MUL_RUN or DIV_RUN.
    - Otherwise go to or stay in IDLE.
    - A new MDU op accepted in DONE starts immediately (back-to-back).
  - MUL_RUN: one shift-add step per cycle for DATA_W cycles. The last step writes the 2·DATA_W product to {mdu_hi,mdu_lo} and moves to DONE.
  - DIV_RUN: one restoring step per cycle for DATA_W cycles, then write quotient→mdu_lo, remainder→mdu_hi, go to DONE.
  - RUN states: in_ready=0, stall=1; inputs are ignored.
  - DONE lasts exactly one cycle with mdu_valid=1.
- Latency: accept at edge E0 → mdu_valid high in the cycle after edge E0+DATA_W, i.e. DATA_W+1 cycles after the accept cycle.
- Divide by zero: DIV_RUN is skipped. Next state is DONE, with mdu_lo=all ones and mdu_hi=dividend. mdu_valid follows 1 cycle after accept.
- mdu_hi/mdu_lo hold their value until the next MDU completion or reset.
- Non-MDU instructions never change FSM state or the mdu_* registers.
- rst during RUN aborts the operation: state goes to IDLE and results clear to 0 on that edge. No mdu_valid is produced.
- in_valid=0 in IDLE: no action. alu_cnt/dec_err still track their inputs.

Optional Feature:
ALU_CTRL_MDU_SIGNED_EN
- Defined: MUL/DIV are two's-complement signed.
  - Operands are converted to magnitudes on accept.
  - The sign is corrected on the final write.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - The divide-by-zero rule is unchanged.
  - The MIN/−1 overflow case gives quotient=MIN, remainder=0.
- Undefined: MUL/DIV are unsigned. The sign-correction logic is absent.

Decomposition:
- Package alu_ctrl_pkg holds:
  - ALU_ADD..ALU_DIV 4-bit codes
  - ALUOP_RTYPE/BRANCH/SLTI/MDU constants
  - FUNCT_* constants
  - MDU_MUL/MDU_DIV type codes
  - the FSM state encoding
- Sub-module mdu_iter holds the datapath: operand/accumulator registers, counter, and shift-add/restoring-subtract step, with start/op/done ports. The FSM and decode stay in alu_ctrl_mdu.

Test Plan:
1. Decode sweep: all funct values at alu_op=000, plus every alu_op/type pair → codes match the decode list. funct=111111 → alu_cnt=0000, dec_err=1.
2. DATA_W=8 MUL 13×11 → stall high for 8 cycles; then mdu_valid pulse with mdu_hi=0x00, mdu_lo=0x8F. Follow with 255×255 → hi=0xFE, lo=0x01.
3. DATA_W=8 DIV 100/7 → lo=14, hi=2, 9 cycles after accept. Then DIV 0x55/0 → lo=0xFF, hi=0x55, mdu_valid the cycle after accept, stall never high.
4. Back-to-back: issue a DIV in the DONE cycle of a MUL → accepted with no idle gap; the MUL results stay visible until the DIV completes.
5. rst asserted 3 cycles into MUL_RUN → next cycle IDLE, stall=0, mdu_hi/lo=0, no mdu_valid.
6. With ALU_CTRL_MDU_SIGNED_EN, DATA_W=8: −6×3 → hi=0xFF, lo=0xEE. −7/2 → lo=0xFD, hi=0xFF. −128/−1 → lo=0x80, hi=0x00.
